// File: rtl/trace_pkg.sv
// Shared types and constants for the trace capture path: record layout,
// reserved marker ID and the FIFO level-width helper.
package trace_pkg;

   localparam int unsigned TRACE_ID_W   = 8;
   localparam int unsigned TRACE_ADDR_W = 32;
   localparam int unsigned TRACE_TS_W   = 32;

   localparam logic [TRACE_ID_W-1:0] MARKER_ID = {TRACE_ID_W{1'b1}};

   typedef struct packed {
      logic [TRACE_ID_W-1:0]   id;
      logic [TRACE_ADDR_W-1:0] addr;
      logic [TRACE_TS_W-1:0]   ts;
   } trace_rec_t;

   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Register-based synchronous FIFO; the extra pointer MSB tells full from empty.
// Callers must not push when full without a same-cycle pop, nor pop when empty.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int unsigned WIDTH = 72,
   parameter int unsigned DEPTH = 16
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           push_i,
   input  logic [WIDTH-1:0]               wdata_i,
   input  logic                           pop_i,
   output logic [WIDTH-1:0]               rdata_o,
   output logic [level_width(DEPTH)-1:0]  level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;

   // Storage array and read/write pointers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
            wr_ptr_q                <= wr_ptr_q + PTR_ONE;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
   assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/trace_event_buffer.sv
// Captures accepted requests as timestamped records, buffers them, and drains
// one per cycle to the logger; drops are counted and reported as marker records.
module trace_event_buffer
   import trace_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned TS_WIDTH   = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned DROP_WIDTH = 16
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         capture_en,
   input  logic                         drain_en,
   input  logic                         req_valid,
   input  logic                         req_ready,
   input  logic [ADDR_WIDTH-1:0]        req_addr,
   input  logic [ID_WIDTH-1:0]          req_id,
   output logic                         log_trigger,
   output logic [ID_WIDTH+ADDR_WIDTH-1:0] log_in0,
   output logic [TS_WIDTH-1:0]          log_in1,
   output logic [DROP_WIDTH-1:0]        drop_count,
   output logic [$clog2(DEPTH):0]       fifo_level
);

   localparam int unsigned LW = level_width(DEPTH);
   localparam int unsigned RW = ID_WIDTH + ADDR_WIDTH + TS_WIDTH;
   localparam logic [LW-1:0]         DEPTH_LVL = LW'(DEPTH);
   localparam logic [ID_WIDTH-1:0]   MARK_ID   = {ID_WIDTH{1'b1}};
   localparam logic [DROP_WIDTH-1:0] DROP_MAX  = {DROP_WIDTH{1'b1}};
   localparam logic [DROP_WIDTH-1:0] DROP_ONE  = {{(DROP_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [TS_WIDTH-1:0]   TS_ONE    = {{(TS_WIDTH-1){1'b0}}, 1'b1};

   logic [TS_WIDTH-1:0]             ts_q;
   logic [DROP_WIDTH-1:0]           drop_count_q, drop_count_d;
   logic [DROP_WIDTH-1:0]           pend_q, pend_d;
   logic                            trig_q;
   logic [ID_WIDTH+ADDR_WIDTH-1:0]  in0_q;
   logic [TS_WIDTH-1:0]             in1_q;

   logic [LW-1:0] level_s;
   logic [RW-1:0] rdata_s;
   logic [RW-1:0] wdata_s;
   logic          cap_s, pop_s, room_s, drop_s, push_mark_s, push_s;

   // Capture/marker arbitration and drop bookkeeping.
   always_comb begin
      cap_s       = req_valid & req_ready & capture_en;
      pop_s       = drain_en & (level_s != {LW{1'b0}});
      room_s      = (level_s < DEPTH_LVL) | pop_s;
      drop_s      = cap_s & ~room_s;
      push_mark_s = ~cap_s & (pend_q != {DROP_WIDTH{1'b0}}) & room_s;
      push_s      = (cap_s & room_s) | push_mark_s;

      if (cap_s) begin
         wdata_s = {req_id, req_addr, ts_q};
      end else begin
         wdata_s = {MARK_ID, ADDR_WIDTH'(pend_q), ts_q};
      end

      drop_count_d = drop_count_q;
      if (drop_s && (drop_count_q != DROP_MAX)) begin
         drop_count_d = drop_count_q + DROP_ONE;
      end else begin
         drop_count_d = drop_count_q;
      end

      pend_d = pend_q;
      if (drop_s) begin
         pend_d = (pend_q == DROP_MAX) ? pend_q : pend_q + DROP_ONE;
      end else if (push_mark_s) begin
         pend_d = {DROP_WIDTH{1'b0}};
      end else begin
         pend_d = pend_q;
      end
   end

   // Timestamp, drop counters and the logger-facing output register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ts_q         <= {TS_WIDTH{1'b0}};
         drop_count_q <= {DROP_WIDTH{1'b0}};
         pend_q       <= {DROP_WIDTH{1'b0}};
         trig_q       <= 1'b0;
         in0_q        <= {(ID_WIDTH+ADDR_WIDTH){1'b0}};
         in1_q        <= {TS_WIDTH{1'b0}};
      end else begin
         ts_q         <= ts_q + TS_ONE;
         drop_count_q <= drop_count_d;
         pend_q       <= pend_d;
         trig_q       <= pop_s;
         if (pop_s) begin
            in0_q <= rdata_s[RW-1:TS_WIDTH];
            in1_q <= rdata_s[TS_WIDTH-1:0];
         end
      end
   end

   trace_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (push_s),
      .wdata_i (wdata_s),
      .pop_i   (pop_s),
      .rdata_o (rdata_s),
      .level_o (level_s)
   );

   assign log_trigger = trig_q;
   assign log_in0     = in0_q;
   assign log_in1     = in1_q;
   assign drop_count  = drop_count_q;
   assign fifo_level  = level_s;

endmodule

// File: doc/trace_event_buffer.md
# trace_event_buffer

Capture stage directly upstream of the simulation file logger. Watches a memory request valid/ready channel. Each accepted request becomes a timestamped record in a small FIFO, drained one record per cycle onto the logger's trigger/in0/in1 inputs. Overflow is never silent: drops are counted and reported in-band as marker records.

## Interface
- ADDR_WIDTH, 32, request address width
- ID_WIDTH, 8, request ID width (≥2)
- TS_WIDTH, 32, timestamp width
- DEPTH, 16, FIFO entries; power of two, ≥2
- DROP_WIDTH, 16, drop counter width (≤ ADDR_WIDTH)

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- capture_en  in  1  enables capture of handshakes
- drain_en  in  1  permits FIFO pops toward the logger
- req_valid  in  1  monitored channel valid
- req_ready  in  1  monitored channel ready
- req_addr  in  ADDR_WIDTH  monitored address
- req_id  in  ID_WIDTH  monitored ID
- log_trigger  out  1  record valid this cycle; wired to logger trigger
- log_in0  out  ID_WIDTH+ADDR_WIDTH  {id, addr} of record
- log_in1  out  TS_WIDTH  timestamp of record
- drop_count  out  DROP_WIDTH  total dropped events, saturating
- fifo_level  out  clog2(DEPTH)+1  current occupancy

## Operation
- Timestamp counter: free-running; +1 every cycle regardless of enables; wraps modulo 2^TS_WIDTH.
- Capture event: req_valid && req_ready && capture_en sampled at a rising edge. Record is {req_id, req_addr, ts}, where ts is the counter value in that cycle.
- Push accepted if level < DEPTH, or if a pop happens the same cycle.
- If a capture event cannot be pushed, it is dropped:
  - drop_count increments (saturates at all-ones).
  - pending_drops increments (saturating, same width).
- Marker push: pending_drops ≠ 0, no capture event this cycle, and a push would be accepted.
  - Marker record: id = all-ones (reserved MARKER_ID), addr = zero-extended pending_drops, ts = current counter.
  - pending_drops clears to 0 in the same edge. A drop in that same cycle is impossible, because a marker push implies no capture event.
- Capture always has priority over marker. Markers may be deferred indefinitely while captures keep arriving.
- Pop: drain_en && level ≠ 0. The popped record is registered onto log_in0/log_in1, and log_trigger = 1 for exactly that following cycle.
- No pop: log_trigger = 0, and log_in0/log_in1 hold their last values.
- No back-pressure is exerted on the monitored channel; the block is observe-only.

## Timing
- Reset values: log_trigger 0, log_in0 0, log_in1 0, drop_count 0, fifo_level 0, timestamp 0, pending_drops 0, FIFO empty.
- Latency with empty FIFO and drain_en held high:
  - Capture at edge k.
  - log_trigger high between edges k+1 and k+2.
  - Logger samples the record at edge k+2.
- Throughput: one push and one pop per cycle. Simultaneous push and pop leaves level unchanged, including at level == DEPTH.
- Full with no pop: capture is dropped that cycle. A pop in the same cycle rescues it.
- Empty with push: the record cannot pop in the same cycle (no fall-through).
- drain_en low: FIFO fills; drops begin once level == DEPTH.
- reset_n asserted mid-operation: all state clears immediately (async). Outputs go to reset values without waiting for a clock edge; queued records are lost, not flushed.
- Timestamp wrap: ts goes from all-ones to 0. No special handling.

## Structure
- Package trace_pkg holds:
  - MARKER_ID constant (all-ones).
  - Packed record struct {id, addr, ts}.
  - Level-width helper function.
- One sub-module, trace_fifo: synchronous register FIFO with push/pop/level. Wrap via pointer MSB. No fall-through.
- The top level holds the timestamp counter, capture/marker arbitration, drop counters, and the output register.

## Test plan
- Single capture: capture_en = 1, drain_en = 1, one handshake with id = 0x05, addr = 0x1000 at cycle 10 → log_trigger high once, 2 edges later; log_in0 = 0x05_00001000; log_in1 = 10.
- Back-to-back: 20 consecutive handshakes with drain_en = 1 → 20 records in order, one per cycle, consecutive timestamps, level never exceeds 1, drop_count = 0.
- Overflow: drain_en = 0, DEPTH+3 handshakes, then drain_en = 1 and channel idle →
  - DEPTH original records, then one marker with id = 0xFF, addr = 3.
  - drop_count = 3.
- Capture priority: with pending_drops = 2 and handshakes every cycle at level < DEPTH → no marker until the first idle cycle; marker addr equals the accumulated count.
- Full simultaneous push/pop: level == DEPTH, drain_en = 1, handshake that cycle → accepted, no drop, level stays DEPTH.
- Async reset: assert reset_n low between edges with level = 5 and log_trigger = 1 → outputs 0 immediately. After release, first capture gets timestamp counted from 0.
